butterfly_r2_pipe: RTL and testbench

- Parametrised, fully pipelined radix-2 DIT butterfly for the FFT datapath: out0 = in0 + in1·W, out1 = in0 − in1·W.
- Adds four things to the existing fixed-width butterfly: generic width and Q-format, valid/ready flow control with stall, a per-sample inverse (conjugate-twiddle) mode and a per-sample divide-by-2 scaling.
- Also provides round-half-up requantisation, output saturation, a sticky overflow flag and a sideband tag carried alongside each sample.
- Sits between the FFT stage address generator/memory and the next stage buffer.

---
 rtl/butterfly_r2_pipe.sv | 182 ++++++++++++++++++
 tb/tb_butterfly_r2_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_r2_pipe.sv
// Radix-2 DIT butterfly, 4-stage pipeline with valid/ready backpressure.
// out0 = in0 + in1*W, out1 = in0 - in1*W; optional conj(W), /2 scaling, saturation.
module butterfly_r2_pipe #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in0_r,
    input  logic [DATA_W-1:0] in0_i,
    input  logic [DATA_W-1:0] in1_r,
    input  logic [DATA_W-1:0] in1_i,
    input  logic [DATA_W-1:0] twiddle_r,
    input  logic [DATA_W-1:0] twiddle_i,
    input  logic              inverse,
    input  logic              scale,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out0_r,
    output logic [DATA_W-1:0] out0_i,
    output logic [DATA_W-1:0] out1_r,
    output logic [DATA_W-1:0] out1_i,
    output logic [TAG_W-1:0]  out_tag,
    output logic              ovf,
    input  logic              ovf_clr
);
    localparam int PW = 2 * DATA_W;
    localparam int CW = PW + 1;
    localparam int EW = DATA_W + 2;
    localparam logic signed [CW-1:0] RND = {{(CW-1){1'b0}}, 1'b1} << (FRAC_W - 1);
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic signed [PW-1:0] sx_p(input logic [DATA_W-1:0] v);
        return {{DATA_W{v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [CW-1:0] sx_c(input logic [PW-1:0] v);
        return {v[PW-1], v};
    endfunction

    // Returns {clamped, result} for a +/- p, optional halving, saturated to DATA_W.
    function automatic logic [DATA_W:0] s4_calc(input logic [DATA_W-1:0] a,
                                                input logic [EW-1:0] p,
                                                input logic sub, input logic sc);
        logic signed [EW-1:0] s;
        logic signed [EW:0]   h;
        logic signed [EW:0]   t;
        logic [DATA_W:0]      res;
        s = sub ? ({a[DATA_W-1], a[DATA_W-1], a} - p) : ({a[DATA_W-1], a[DATA_W-1], a} + p);
        h = {s[EW-1], s} + (EW + 1)'(1);
        if (sc) t = h >>> 1;
        else    t = {s[EW-1], s};
        if (t[EW:DATA_W-1] != '0 && t[EW:DATA_W-1] != '1)
            res = {1'b1, (t[EW] ? SAT_MIN : SAT_MAX)};
        else
            res = {1'b0, t[DATA_W-1:0]};
        return res;
    endfunction

    logic w_stall;
    logic r_v1, r_v2, r_v3, r_v4;

    assign w_stall   = r_v4 & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_v4;

    // Stage 1: operand capture
    logic [DATA_W-1:0] r_a0r, r_a0i, r_a1r, r_a1i, r_wr, r_wi;
    logic              r_inv1, r_sc1;
    logic [TAG_W-1:0]  r_tag1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_a0r <= '0; r_a0i <= '0; r_a1r <= '0; r_a1i <= '0; r_wr <= '0; r_wi <= '0;
            r_inv1 <= 1'b0; r_sc1 <= 1'b0; r_tag1 <= '0;
        end else if (!w_stall) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_a0r <= in0_r; r_a0i <= in0_i; r_a1r <= in1_r; r_a1i <= in1_i;
                r_wr <= twiddle_r; r_wi <= twiddle_i;
                r_inv1 <= inverse; r_sc1 <= scale; r_tag1 <= in_tag;
            end
        end
    end

    // Stage 2: full-width partial products
    logic signed [PW-1:0] r_prr, r_pii, r_pri, r_pir;
    logic [DATA_W-1:0]    r_a0r2, r_a0i2;
    logic                 r_inv2, r_sc2;
    logic [TAG_W-1:0]     r_tag2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2 <= 1'b0;
            r_prr <= '0; r_pii <= '0; r_pri <= '0; r_pir <= '0;
            r_a0r2 <= '0; r_a0i2 <= '0; r_inv2 <= 1'b0; r_sc2 <= 1'b0; r_tag2 <= '0;
        end else if (!w_stall) begin
            r_v2   <= r_v1;
            r_prr  <= sx_p(r_a1r) * sx_p(r_wr);
            r_pii  <= sx_p(r_a1i) * sx_p(r_wi);
            r_pri  <= sx_p(r_a1r) * sx_p(r_wi);
            r_pir  <= sx_p(r_a1i) * sx_p(r_wr);
            r_a0r2 <= r_a0r; r_a0i2 <= r_a0i;
            r_inv2 <= r_inv1; r_sc2 <= r_sc1; r_tag2 <= r_tag1;
        end
    end

    // Stage 3: complex combine, round half up, requantise
    logic signed [CW-1:0] w_cr, w_ci, w_sr, w_si;
    logic                 w_unused_hi;
    logic [EW-1:0]        r_p3r, r_p3i;
    logic [DATA_W-1:0]    r_a0r3, r_a0i3;
    logic                 r_sc3;
    logic [TAG_W-1:0]     r_tag3;

    always_comb begin
        w_cr = r_inv2 ? (sx_c(r_prr) + sx_c(r_pii)) : (sx_c(r_prr) - sx_c(r_pii));
        w_ci = r_inv2 ? (sx_c(r_pir) - sx_c(r_pri)) : (sx_c(r_pri) + sx_c(r_pir));
        w_sr = (w_cr + RND) >>> FRAC_W;
        w_si = (w_ci + RND) >>> FRAC_W;
    end

    assign w_unused_hi = ^{w_sr[CW-1:EW], w_si[CW-1:EW]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3 <= 1'b0;
            r_p3r <= '0; r_p3i <= '0; r_a0r3 <= '0; r_a0i3 <= '0; r_sc3 <= 1'b0; r_tag3 <= '0;
        end else if (!w_stall) begin
            r_v3   <= r_v2;
            r_p3r  <= w_sr[EW-1:0];
            r_p3i  <= w_si[EW-1:0];
            r_a0r3 <= r_a0r2; r_a0i3 <= r_a0i2;
            r_sc3  <= r_sc2; r_tag3 <= r_tag2;
        end
    end

    // Stage 4: sum/difference, scaling, saturation, sticky overflow
    logic [DATA_W:0]   w_o0r, w_o0i, w_o1r, w_o1i;
    logic [DATA_W-1:0] r_o0r, r_o0i, r_o1r, r_o1i;
    logic [TAG_W-1:0]  r_tag4;
    logic              r_clamp4, r_ovf;

    always_comb begin
        w_o0r = s4_calc(r_a0r3, r_p3r, 1'b0, r_sc3);
        w_o0i = s4_calc(r_a0i3, r_p3i, 1'b0, r_sc3);
        w_o1r = s4_calc(r_a0r3, r_p3r, 1'b1, r_sc3);
        w_o1i = s4_calc(r_a0i3, r_p3i, 1'b1, r_sc3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v4 <= 1'b0;
            r_o0r <= '0; r_o0i <= '0; r_o1r <= '0; r_o1i <= '0;
            r_tag4 <= '0; r_clamp4 <= 1'b0; r_ovf <= 1'b0;
        end else begin
            if (!w_stall) begin
                r_v4 <= r_v3;
                if (r_v3) begin
                    r_o0r <= w_o0r[DATA_W-1:0]; r_o0i <= w_o0i[DATA_W-1:0];
                    r_o1r <= w_o1r[DATA_W-1:0]; r_o1i <= w_o1i[DATA_W-1:0];
                    r_tag4   <= r_tag3;
                    r_clamp4 <= w_o0r[DATA_W] | w_o0i[DATA_W] | w_o1r[DATA_W] | w_o1i[DATA_W];
                end
            end
            r_ovf <= (r_ovf & ~ovf_clr) | (r_v4 & out_ready & r_clamp4);
        end
    end

    assign out0_r  = r_o0r;
    assign out0_i  = r_o0i;
    assign out1_r  = r_o1r;
    assign out1_i  = r_o1i;
    assign out_tag = r_tag4;
    assign ovf     = r_ovf;
endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Randomised bench for butterfly_r2_pipe against a wide-integer reference model
// with an expected-output queue, plus the directed corner beats.
module tb_butterfly_r2_pipe;
    localparam int DW = 32;
    localparam int FW = 16;
    localparam int TW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_ready, inverse, scale, out_valid, out_ready, ovf, ovf_clr;
    logic [DW-1:0] in0_r, in0_i, in1_r, in1_i, twiddle_r, twiddle_i;
    logic [DW-1:0] out0_r, out0_i, out1_r, out1_i;
    logic [TW-1:0] in_tag, out_tag;

    butterfly_r2_pipe #(.DATA_W(DW), .FRAC_W(FW), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in0_r(in0_r), .in0_i(in0_i), .in1_r(in1_r), .in1_i(in1_i),
        .twiddle_r(twiddle_r), .twiddle_i(twiddle_i),
        .inverse(inverse), .scale(scale), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0_r(out0_r), .out0_i(out0_i), .out1_r(out1_r), .out1_i(out1_i),
        .out_tag(out_tag), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    typedef struct {
        logic [DW-1:0] a0r, a0i, a1r, a1i, wr, wi;
        logic          inv, sc;
        logic [TW-1:0] tag;
    } beat_t;

    typedef struct {
        logic [DW-1:0] o0r, o0i, o1r, o1i;
        logic [TW-1:0] tag;
        logic          clamp;
        int            acc;
    } exp_t;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    n_out    = 0;
    bit    lat_exact = 1'b0;
    bit    exp_ovf   = 1'b0;
    bit    prev_stall = 1'b0;
    logic [159:0] prev_vals;
    logic [DW-1:0] lo0r, lo0i, lo1r, lo1i;
    logic [TW-1:0] ltag;
    beat_t tx_q[$];
    exp_t  exp_q[$];

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic signed [127:0] sx(input logic [DW-1:0] v);
        return {{(128-DW){v[DW-1]}}, v};
    endfunction

    // Two's-complement wrap to DW+2 bits
    function automatic logic signed [127:0] wrap_e(input logic signed [127:0] v);
        logic signed [127:0] t;
        t = v <<< (128 - (DW + 2));
        return t >>> (128 - (DW + 2));
    endfunction

    function automatic logic [DW:0] sat(input logic signed [127:0] v);
        if (v > sx(32'h7FFFFFFF)) return {1'b1, 32'h7FFFFFFF};
        if (v < sx(32'h80000000)) return {1'b1, 32'h80000000};
        return {1'b0, DW'(v)};
    endfunction

    function automatic exp_t model(input beat_t b);
        logic signed [127:0] ar, ai, wr, wi, pr, pi, qr, qi, s0r, s0i, s1r, s1i;
        logic [DW:0] r0r, r0i, r1r, r1i;
        exp_t e;
        ar = sx(b.a1r); ai = sx(b.a1i); wr = sx(b.wr); wi = sx(b.wi);
        if (!b.inv) begin
            pr = ar * wr - ai * wi;
            pi = ar * wi + ai * wr;
        end else begin
            pr = ar * wr + ai * wi;
            pi = ai * wr - ar * wi;
        end
        qr = wrap_e((pr + (128'sd1 <<< (FW - 1))) >>> FW);
        qi = wrap_e((pi + (128'sd1 <<< (FW - 1))) >>> FW);
        s0r = wrap_e(sx(b.a0r) + qr); s0i = wrap_e(sx(b.a0i) + qi);
        s1r = wrap_e(sx(b.a0r) - qr); s1i = wrap_e(sx(b.a0i) - qi);
        if (b.sc) begin
            s0r = (s0r + 128'sd1) >>> 1; s0i = (s0i + 128'sd1) >>> 1;
            s1r = (s1r + 128'sd1) >>> 1; s1i = (s1i + 128'sd1) >>> 1;
        end
        r0r = sat(s0r); r0i = sat(s0i); r1r = sat(s1r); r1i = sat(s1i);
        e.o0r = r0r[DW-1:0]; e.o0i = r0i[DW-1:0];
        e.o1r = r1r[DW-1:0]; e.o1i = r1i[DW-1:0];
        e.clamp = r0r[DW] | r0i[DW] | r1r[DW] | r1i[DW];
        e.tag = b.tag;
        e.acc = cyc;
        return e;
    endfunction

    function automatic beat_t mk(input logic [DW-1:0] a0r, a0i, a1r, a1i, wr, wi,
                                 input logic inv, sc, input logic [TW-1:0] tag);
        beat_t b;
        b.a0r = a0r; b.a0i = a0i; b.a1r = a1r; b.a1i = a1i; b.wr = wr; b.wi = wi;
        b.inv = inv; b.sc = sc; b.tag = tag;
        return b;
    endfunction

    function automatic logic [DW-1:0] rnd_val();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return DW'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
    endfunction

    function automatic logic [DW-1:0] rnd_tw();
        if ($urandom_range(0, 5) == 0) return $urandom;
        return DW'($urandom_range(0, 32'h1FFFF)) - 32'h10000;
    endfunction

    function automatic beat_t rnd_beat(input logic [TW-1:0] tag);
        return mk(rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_tw(), rnd_tw(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
    endfunction

    task automatic drive(input beat_t b);
        in0_r = b.a0r; in0_i = b.a0i; in1_r = b.a1r; in1_i = b.a1i;
        twiddle_r = b.wr; twiddle_i = b.wi; inverse = b.inv; scale = b.sc; in_tag = b.tag;
    endtask

    always @(posedge clk) cyc++;

    // Monitor: reference queue, in_ready rule, stall stability, sticky ovf
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            prev_stall = 1'b0;
        end else begin
            exp_t e;
            bit xfer_clamp;
            xfer_clamp = 1'b0;
            check_eq("in_ready", 160'(in_ready), 160'(!(out_valid && !out_ready)));
            check_eq("ovf", 160'(ovf), 160'(exp_ovf));
            if (prev_stall)
                check_eq("stall_hold", 160'({out_valid, out0_r, out0_i, out1_r, out1_i, out_tag}), prev_vals);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 160'(1), 160'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out", 160'({out0_r, out0_i, out1_r, out1_i, out_tag}),
                             160'({e.o0r, e.o0i, e.o1r, e.o1i, e.tag}));
                    if (lat_exact) check_eq("latency", 160'(cyc - e.acc), 160'(4));
                    xfer_clamp = e.clamp;
                end
                lo0r = out0_r; lo0i = out0_i; lo1r = out1_r; lo1i = out1_i; ltag = out_tag;
            end
            exp_ovf = (exp_ovf && !ovf_clr) || xfer_clamp;
            if (in_valid && in_ready)
                exp_q.push_back(model(mk(in0_r, in0_i, in1_r, in1_i, twiddle_r, twiddle_i,
                                         inverse, scale, in_tag)));
            prev_stall = out_valid && !out_ready;
            prev_vals = 160'({out_valid, out0_r, out0_i, out1_r, out1_i, out_tag});
        end
    end

    // mode 0: out_ready=1; mode 1: out_ready pattern 1,0,0,1; mode 2: random everything
    task automatic run(input int mode, input int max_cyc);
        int guard = 0;
        int phase = 0;
        while ((tx_q.size() != 0 || exp_q.size() != 0) && guard < max_cyc) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (phase % 4 == 0) || (phase % 4 == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            ovf_clr = (mode == 2) && ($urandom_range(0, 7) == 0);
            if (tx_q.size() != 0 && (mode != 2 || $urandom_range(0, 3) != 0)) begin
                drive(tx_q[0]);
                in_valid = 1'b1;
            end else begin
                drive(rnd_beat(8'hEE));
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) void'(tx_q.pop_front());
            @(posedge clk);
            #1;
            guard++;
            phase++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        ovf_clr = 1'b0;
        check_eq("drain", 160'(tx_q.size() + exp_q.size()), 160'(0));
    endtask

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        drive(mk('0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 160'(out_valid), 160'(0));
        check_eq("rst_data", 160'({out0_r, out0_i, out1_r, out1_i, out_tag}), 160'(0));
        check_eq("rst_ovf", 160'(ovf), 160'(0));
        check_eq("rst_in_ready", 160'(in_ready), 160'(1));
        @(posedge clk); #1;

        lat_exact = 1'b1;
        tx_q.push_back(mk(32'h00010000, 0, 32'h00008000, 0, 32'h00010000, 0, 1'b0, 1'b0, 8'h5A));
        run(0, 50);
        check_eq("basic", 160'({lo0r, lo0i, lo1r, lo1i, ltag}),
                 160'({32'h00018000, 32'h0, 32'h00008000, 32'h0, 8'h5A}));

        tx_q.push_back(mk(0, 0, 32'h00010000, 0, 0, 32'hFFFF0000, 1'b0, 1'b0, 8'h01));
        run(0, 50);
        check_eq("tw_fwd", 160'({lo0r, lo0i, lo1r, lo1i}), 160'({32'h0, 32'hFFFF0000, 32'h0, 32'h00010000}));
        tx_q.push_back(mk(0, 0, 32'h00010000, 0, 0, 32'hFFFF0000, 1'b1, 1'b0, 8'h02));
        run(0, 50);
        check_eq("tw_inv", 160'({lo0r, lo0i, lo1r, lo1i}), 160'({32'h0, 32'h00010000, 32'h0, 32'hFFFF0000}));

        tx_q.push_back(mk(32'h7FFF0000, 0, 32'h7FFF0000, 0, 32'h00010000, 0, 1'b0, 1'b0, 8'h03));
        run(0, 50);
        check_eq("sat_o0r", 160'(lo0r), 160'(32'h7FFFFFFF));
        check_eq("sat_o1r", 160'(lo1r), 160'(32'h0));
        check_eq("sat_ovf", 160'(ovf), 160'(1));
        ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        check_eq("ovf_clr", 160'(ovf), 160'(0));
        tx_q.push_back(mk(32'h7FFF0000, 0, 32'h7FFF0000, 0, 32'h00010000, 0, 1'b0, 1'b1, 8'h04));
        run(0, 50);
        @(posedge clk); #1;
        check_eq("scale_o0r", 160'(lo0r), 160'(32'h7FFF0000));
        check_eq("scale_ovf", 160'(ovf), 160'(0));

        tx_q.push_back(mk(0, 0, 32'h00000001, 0, 32'h00008000, 0, 1'b0, 1'b0, 8'h05));
        run(0, 50);
        check_eq("round_up", 160'({lo0r, lo1r}), 160'({32'h00000001, 32'hFFFFFFFF}));
        tx_q.push_back(mk(0, 0, 32'hFFFFFFFF, 0, 32'h00008000, 0, 1'b0, 1'b0, 8'h06));
        run(0, 50);
        check_eq("round_neg", 160'({lo0r, lo1r}), 160'({32'h0, 32'h0}));

        lat_exact = 1'b0;
        base = n_out;
        for (int i = 0; i < 10; i++) tx_q.push_back(rnd_beat(TW'(8'h10 + i)));
        run(1, 400);
        check_eq("bp_count", 160'(n_out - base), 160'(10));

        // Reset with three beats in flight, ovf set beforehand
        lat_exact = 1'b1;
        tx_q.push_back(mk(32'h7FFF0000, 0, 32'h7FFF0000, 0, 32'h00010000, 0, 1'b0, 1'b0, 8'h20));
        run(0, 50);
        check_eq("pre_rst_ovf", 160'(ovf), 160'(1));
        base = n_out;
        for (int i = 0; i < 3; i++) begin
            drive(rnd_beat(TW'(8'h30 + i)));
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", 160'(out_valid), 160'(0));
        check_eq("mid_rst_ovf", 160'(ovf), 160'(0));
        repeat (8) @(posedge clk);
        #1;
        check_eq("mid_rst_none", 160'(n_out - base), 160'(0));
        tx_q.push_back(rnd_beat(8'h40));
        run(0, 50);
        check_eq("post_rst_beat", 160'(n_out - base), 160'(1));

        for (int i = 0; i < 40; i++) tx_q.push_back(rnd_beat(TW'(i)));
        run(0, 400);
        lat_exact = 1'b0;
        for (int i = 0; i < 60; i++) tx_q.push_back(rnd_beat(TW'(8'h80 + i)));
        run(2, 2000);
        for (int i = 0; i < 40; i++) tx_q.push_back(rnd_beat(TW'(8'hC0 + i)));
        run(1, 1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
